mux_reg: RTL and testbench

- Parameterised 2^sel_width-to-1 single-bit multiplexer with a registered output.
- Selects one bit of the `in` bus by binary index `sel` and presents it on `out` one clock later, with a qualifying valid flag and the registered index used.
- Used as a generic bit-select stage in datapaths that need a clean, glitch-free registered select output.

---
 rtl/mux_reg.sv | 42 ++++
 tb/tb_mux_reg.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mux_reg.sv
// Registered 2**sel_width-to-1 single-bit multiplexer.
// Captures in[sel] on enabled edges and reports the index and a one-cycle valid flag.
module mux_reg #(
    parameter int unsigned sel_width = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [2**sel_width-1:0] in,
    input  logic [sel_width-1:0]    sel,
    output logic                    out,
    output logic                    out_valid,
    output logic [sel_width-1:0]    sel_q
);

    logic                 r_out;
    logic                 r_valid;
    logic [sel_width-1:0] r_sel;
    logic                 w_bit;

    // Indexed select reads only the addressed bit, so X/Z elsewhere cannot leak in.
    assign w_bit = in[sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else if (en) begin
            r_out   <= w_bit;
            r_valid <= 1'b1;
            r_sel   <= sel;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign sel_q     = r_sel;

endmodule

// File: tb/tb_mux_reg.sv
// Self-checking bench for mux_reg: directed scenarios plus randomized traffic
// compared against a shift-and-mask reference model.
module tb_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // sel_width = 3 instance
    logic       rst, en;
    logic [7:0] in_b;
    logic [2:0] sel;
    logic       out, out_valid;
    logic [2:0] sel_q;

    // sel_width = 1 instance
    logic       rst1, en1;
    logic [1:0] in1;
    logic       sel1;
    logic       out1, out_valid1;
    logic       sel_q1;

    int checks = 0;
    int errors = 0;

    logic       m_out, m_valid;
    logic [2:0] m_sel;
    logic       m_out1, m_valid1, m_sel1;

    mux_reg #(.sel_width(3)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in_b), .sel(sel),
        .out(out), .out_valid(out_valid), .sel_q(sel_q)
    );

    mux_reg #(.sel_width(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .in(in1), .sel(sel1),
        .out(out1), .out_valid(out_valid1), .sel_q(sel_q1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle to the 8-bit instance, advance the model, compare.
    task automatic step(input logic r, input logic e, input logic [7:0] d, input logic [2:0] s,
                        input string tag);
        logic [7:0] t;
        rst = r; en = e; in_b = d; sel = s;
        @(posedge clk);
        if (r) begin
            m_out = 1'b0; m_valid = 1'b0; m_sel = 3'd0;
        end else if (e) begin
            t = (d >> s) & 8'd1;
            m_out = t[0]; m_valid = 1'b1; m_sel = s;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ".out"},       {7'd0, out},       {7'd0, m_out});
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, m_valid});
        chk({tag, ".sel_q"},     {5'd0, sel_q},     {5'd0, m_sel});
    endtask

    task automatic step1(input logic r, input logic e, input logic [1:0] d, input logic s,
                         input string tag);
        logic [1:0] t;
        rst1 = r; en1 = e; in1 = d; sel1 = s;
        @(posedge clk);
        if (r) begin
            m_out1 = 1'b0; m_valid1 = 1'b0; m_sel1 = 1'b0;
        end else if (e) begin
            t = (d >> s) & 2'd1;
            m_out1 = t[0]; m_valid1 = 1'b1; m_sel1 = s;
        end else begin
            m_valid1 = 1'b0;
        end
        #1;
        chk({tag, ".out"},       {7'd0, out1},       {7'd0, m_out1});
        chk({tag, ".out_valid"}, {7'd0, out_valid1}, {7'd0, m_valid1});
        chk({tag, ".sel_q"},     {7'd0, sel_q1},     {7'd0, m_sel1});
    endtask

    initial begin
        logic [7:0] xd;
        logic [7:0] cnt;
        logic [2:0] s;
        logic       b;

        rst = 1'b1; en = 1'b1; in_b = 8'hFF; sel = 3'd5;
        rst1 = 1'b1; en1 = 1'b0; in1 = 2'b00; sel1 = 1'b0;

        // Reset held with en=1: outputs stay cleared.
        step(1'b1, 1'b1, 8'hFF, 3'd5, "reset0");
        step(1'b1, 1'b1, 8'hFF, 3'd5, "reset1");
        chk("reset.out_const", {7'd0, out}, 8'd0);

        // Full sweep with a one-cycle reset injected mid-stream.
        cnt = 8'd0;
        for (int unsigned i = 0; i < 256; i++) begin
            s = 3'(i / 32);
            if (i == 100)
                step(1'b1, 1'b1, cnt, s, "sweep_rst");
            else
                step(1'b0, 1'b1, cnt, s, "sweep");
            cnt = cnt + 8'd1;
        end

        // MSB/LSB boundaries.
        step(1'b0, 1'b1, 8'h80, 3'd7, "msb");
        chk("msb.out_const", {7'd0, out}, 8'd1);
        step(1'b0, 1'b1, 8'h80, 3'd0, "lsb0");
        step(1'b0, 1'b1, 8'h01, 3'd0, "lsb1");

        // Enable hold.
        step(1'b0, 1'b1, 8'h10, 3'd4, "hold_cap");
        for (int unsigned i = 0; i < 3; i++)
            step(1'b0, 1'b0, 8'h00, 3'd1, "hold");
        chk("hold.sel_q_const", {5'd0, sel_q}, 8'd4);

        // Unselected bits driven X must not disturb the result.
        for (int unsigned i = 0; i < 16; i++) begin
            s = 3'($urandom_range(0, 7));
            b = 1'($urandom_range(0, 1));
            xd = 'x;
            xd[s] = b;
            step(1'b0, 1'b1, xd, s, "xsafe");
        end

        // Randomized traffic.
        for (int unsigned i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 3'($urandom_range(0, 7)), "rand");
        end

        // Narrowest parameterisation.
        step1(1'b1, 1'b0, 2'b00, 1'b0, "w1_rst");
        step1(1'b0, 1'b1, 2'b10, 1'b1, "w1_sel1");
        step1(1'b0, 1'b1, 2'b10, 1'b0, "w1_sel0");
        step1(1'b0, 1'b0, 2'b01, 1'b0, "w1_hold");
        for (int unsigned i = 0; i < 20; i++)
            step1(1'b0, ($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), "w1_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
